via_ca_ctrl: RTL and testbench
==============================

Name: via_ca_ctrl

Overview:
- CA1/CA2 control-line and interrupt-flag stage of the VIA 6522 port A path.
- Synchronizes the CA1/CA2 pins and detects the PCR-selected active edge on each.
- Sets and clears the CA1/CA2 IFR bits, latches PA on an active CA1 edge, and drives CA2 in its output modes (handshake, pulse, manual).
- Consumes the register-file strobes and feeds the IFR/IRQ aggregation logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for CA1/CA2 pins (minimum 2).
- PA_W, 8, port A width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ce  in  1  clock enable (phi2 tick); all state advances only when ce=1.
- ca1_i  in  1  CA1 pin.
- ca2_i  in  1  CA2 pin (used in input modes).
- ca2_o  out  1  CA2 output value.
- ca2_oe  out  1  CA2 output enable; 1 when pcr[3]=1.
- pcr  in  4  PCR[3:0]. Bit 0 is CA1 edge select: 0=neg, 1=pos. Bits [3:1] are CA2 mode.
- acr_pa_le  in  1  ACR bit 0, PA latch enable.
- pa_i  in  PA_W  port A pin values.
- pa_lat  out  PA_W  latched PA value.
- ora_rd  in  1  one-ce strobe, ORA (reg 1) read.
- ora_wr  in  1  one-ce strobe, ORA (reg 1) write.
- ifr_wr  in  1  IFR write strobe.
- ifr_wdata  in  2  IFR write data bits [1:0]; a 1 clears the corresponding flag.
- ier  in  2  IER bits [1:0].
- ifr  out  2  {CA1 flag, CA2 flag} = IFR[1:0].
- irq_ca  out  1  |(ifr & ier).

Behaviour:
- Reset values (async, rst_n=0): ifr=0, pa_lat=0, ca2_o=1, synchronizer and previous-state registers all 1. Lines idling high after reset therefore produce no edge.
- Synchronizer and edge detection:
  - SYNC_STAGES flops per pin, advanced on ce.
  - A prev register holds the last synced value.
  - pe = ~prev & sync; ne = prev & ~sync.
- CA1 active edge: pcr[0] ? pe1 : ne1.
  - On the ce cycle the active edge is seen: ifr[1] <= 1.
  - If acr_pa_le=1, pa_lat <= pa_i on that same cycle.
  - If acr_pa_le=0, pa_lat tracks pa_i every ce.
- Latency: a pin transition captured at ce edge k gives flag=1 after ce edge k+SYNC_STAGES (3rd ce edge for the default).
- CA2 modes, pcr[3:1]:
  - 000: input, neg edge sets ifr[0]; ORA rd/wr clears ifr[0].
  - 001: input, neg edge, independent; ORA access does not clear.
  - 010: input, pos edge; ORA rd/wr clears ifr[0].
  - 011: input, pos edge, independent.
  - 100: handshake output. ca2_o <= 0 on ora_rd or ora_wr; ca2_o <= 1 on a CA1 active edge. If both occur in the same cycle, the CA1 edge wins (ca2_o=1).
  - 101: pulse output. ca2_o=0 for exactly one ce cycle following an ORA rd/wr, then 1. Back-to-back strobes extend the low time.
  - 110: ca2_o=0 constant.
  - 111: ca2_o=1 constant.
  - In output modes, ifr[0] is never set by CA2.
- ifr[1] clear: ORA rd/wr (any mode) or ifr_wr with ifr_wdata[1]=1.
- ifr[0] clear: ifr_wr with ifr_wdata[0]=1, or ORA access in modes 000/010.
- Simultaneous set and clear in the same ce cycle: set wins (flag=1).
- Mode change mid-operation:
  - Switching to an output mode loads ca2_o per the new mode on the next ce; modes 100/101 load 1.
  - An existing ifr[0] is retained until cleared.
- With ce=0, no register changes except the async reset. ORA/IFR strobes are sampled only with ce=1.
- irq_ca is combinational from the registered ifr and ier.

Test Plan:
- Reset → edge detection: rst_n low then high, ca1_i=ca2_i=1 held → ifr=00, ca2_o=1, pa_lat=0, no spurious flag for 10 ce.
- CA1 neg edge + PA latch: pcr=0000, acr_pa_le=1, pa_i=0xA5, ca1_i 1→0 → ifr[1]=1 after 3rd ce edge, pa_lat=0xA5 held when pa_i then changes to 0x3C. With ier=10, irq_ca=1. ora_rd strobe → ifr[1]=0, irq_ca=0.
- CA2 independent pos edge: pcr=0110, ca2_i 0→1 → ifr[0]=1; ora_wr → ifr[0] stays 1; ifr_wr with ifr_wdata=01 → ifr[0]=0.
- Handshake: pcr=1000, ora_rd → ca2_o=0 next ce. CA1 active edge (neg) → ca2_o=1. ora_rd in the same ce as the CA1 edge → ca2_o=1.
- Pulse: pcr=1010, single ora_wr → ca2_o low exactly 1 ce cycle. Two consecutive ora_wr → low 2 cycles.
- Set/clear collision: CA1 edge reaches the flag in the same ce as ifr_wr with ifr_wdata=10 → ifr[1]=1. Async reset asserted mid-pulse (pcr=1010) → ca2_o=1 immediately, ifr=00.

Source files
------------

// File: rtl/via_ca_ctrl_if.sv
// via_ca_ctrl_if
// Register-file side of the VIA 6522 CA1/CA2 control stage.
//   pcr        : PCR[3:0] (bit 0 = CA1 edge select, [3:1] = CA2 mode)
//   acr_pa_le  : ACR bit 0, PA latch enable
//   ora_rd     : one-ce strobe, ORA read
//   ora_wr     : one-ce strobe, ORA write
//   ifr_wr     : IFR write strobe
//   ifr_wdata  : IFR write data [1:0], a 1 clears the matching flag
//   ier        : IER bits [1:0]
//   ifr        : {CA1 flag, CA2 flag}
//   irq_ca     : |(ifr & ier)
// The register file uses the master modport, the CA stage uses slave.
interface via_ca_ctrl_if;
    logic [3:0] pcr;
    logic       acr_pa_le;
    logic       ora_rd;
    logic       ora_wr;
    logic       ifr_wr;
    logic [1:0] ifr_wdata;
    logic [1:0] ier;
    logic [1:0] ifr;
    logic       irq_ca;

    modport master (
        output pcr, acr_pa_le, ora_rd, ora_wr, ifr_wr, ifr_wdata, ier,
        input  ifr, irq_ca
    );

    modport slave (
        input  pcr, acr_pa_le, ora_rd, ora_wr, ifr_wr, ifr_wdata, ier,
        output ifr, irq_ca
    );
endinterface

// File: rtl/via_ca_ctrl.sv
// via_ca_ctrl
// CA1/CA2 control-line and interrupt-flag stage of the VIA 6522 port A path.
// Synchronizes the CA pins, detects the PCR-selected edges, maintains the
// CA1/CA2 IFR bits, latches port A on CA1 and drives CA2 in output modes.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ce         : phi2 tick; all state advances only when ce=1
//   ca1_i      : CA1 pin
//   ca2_i      : CA2 pin (input modes)
//   ca2_o      : CA2 output value
//   ca2_oe     : CA2 output enable (pcr[3])
//   pa_i       : port A pin values
//   pa_lat     : latched port A value
//   bus        : register-file strobes and IFR/IRQ results (slave side)
// SYNC_STAGES must be at least 2.
module via_ca_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int PA_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              ca1_i,
    input  logic              ca2_i,
    output logic              ca2_o,
    output logic              ca2_oe,
    input  logic [PA_W-1:0]   pa_i,
    output logic [PA_W-1:0]   pa_lat,
    via_ca_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        CA2_IN_NEG     = 3'b000,
        CA2_IN_NEG_IND = 3'b001,
        CA2_IN_POS     = 3'b010,
        CA2_IN_POS_IND = 3'b011,
        CA2_HANDSHAKE  = 3'b100,
        CA2_PULSE      = 3'b101,
        CA2_LOW        = 3'b110,
        CA2_HIGH       = 3'b111
    } ca2_mode_t;

    logic [SYNC_STAGES-1:0] sync1;
    logic [SYNC_STAGES-1:0] sync2;
    logic                   prev1;
    logic                   prev2;
    logic                   ca1_s;
    logic                   ca2_s;
    logic                   ca1_act;
    logic                   ca2_act;
    logic                   ora_acc;
    logic                   ca1_set;
    logic                   ca1_clr;
    logic                   ca2_set;
    logic                   ca2_clr;
    logic [1:0]             ifr_q;
    logic                   ca2_o_next;
    ca2_mode_t              mode;
    ca2_mode_t              mode_q;

    assign mode    = ca2_mode_t'(bus.pcr[3:1]);
    assign ca1_s   = sync1[SYNC_STAGES-1];
    assign ca2_s   = sync2[SYNC_STAGES-1];
    assign ora_acc = bus.ora_rd | bus.ora_wr;

    // Edge selection: pcr[0] picks the CA1 edge, pcr[2] (mode bit 1) picks
    // the CA2 edge. sync and prev only move on ce, so these stay stable
    // between ticks.
    assign ca1_act = bus.pcr[0] ? (~prev1 & ca1_s) : (prev1 & ~ca1_s);
    assign ca2_act = bus.pcr[2] ? (~prev2 & ca2_s) : (prev2 & ~ca2_s);

    // CA2 only raises its flag in input modes; only the non-independent
    // input modes let an ORA access clear it.
    assign ca1_set = ca1_act;
    assign ca1_clr = ora_acc | (bus.ifr_wr & bus.ifr_wdata[1]);
    assign ca2_set = ~bus.pcr[3] & ca2_act;
    assign ca2_clr = (bus.ifr_wr & bus.ifr_wdata[0]) |
                     (ora_acc & ((mode == CA2_IN_NEG) | (mode == CA2_IN_POS)));

    assign bus.ifr    = ifr_q;
    assign bus.irq_ca = |(ifr_q & bus.ier);
    assign ca2_oe     = bus.pcr[3];

    // Synchronizers and previous-value registers idle high so that lines
    // sitting high after reset never look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev1 <= 1'b1;
            prev2 <= 1'b1;
        end else if (ce) begin
            sync1 <= {sync1[SYNC_STAGES-2:0], ca1_i};
            sync2 <= {sync2[SYNC_STAGES-2:0], ca2_i};
            prev1 <= ca1_s;
            prev2 <= ca2_s;
        end
    end

    // Interrupt flags: a set in the same tick as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifr_q <= 2'b00;
        end else if (ce) begin
            if (ca1_set) begin
                ifr_q[1] <= 1'b1;
            end else if (ca1_clr) begin
                ifr_q[1] <= 1'b0;
            end
            if (ca2_set) begin
                ifr_q[0] <= 1'b1;
            end else if (ca2_clr) begin
                ifr_q[0] <= 1'b0;
            end
        end
    end

    // Port A is transparent while latching is disabled, otherwise it is
    // captured on the active CA1 edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_lat <= '0;
        end else if (ce) begin
            if (!bus.acr_pa_le || ca1_act) begin
                pa_lat <= pa_i;
            end
        end
    end

    // Next CA2 output. A mode change reloads the output for the new mode;
    // handshake and pulse start high. In handshake mode the CA1 edge takes
    // priority over an ORA access in the same tick.
    always_comb begin
        ca2_o_next = ca2_o;
        if (mode != mode_q) begin
            ca2_o_next = (mode == CA2_LOW) ? 1'b0 : 1'b1;
        end else begin
            case (mode)
                CA2_HANDSHAKE: begin
                    if (ca1_act) begin
                        ca2_o_next = 1'b1;
                    end else if (ora_acc) begin
                        ca2_o_next = 1'b0;
                    end
                end
                CA2_PULSE: ca2_o_next = ~ora_acc;
                CA2_LOW:   ca2_o_next = 1'b0;
                CA2_HIGH:  ca2_o_next = 1'b1;
                default:   ca2_o_next = 1'b1;
            endcase
        end
    end

    // CA2 output register and the mode seen on the previous tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca2_o  <= 1'b1;
            mode_q <= CA2_IN_NEG;
        end else if (ce) begin
            ca2_o  <= ca2_o_next;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_via_ca_ctrl.sv
// tb_via_ca_ctrl
// Directed bench for via_ca_ctrl: reset state, CA1 edge flag and PA latch,
// CA2 input modes, handshake/pulse/manual outputs, set/clear collisions and
// asynchronous reset. ce is pulsed every other clock.
module tb_via_ca_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       ca1_i;
    logic       ca2_i;
    logic       ca2_o;
    logic       ca2_oe;
    logic [7:0] pa_i;
    logic [7:0] pa_lat;

    int checks;
    int errors;

    via_ca_ctrl_if bus ();

    via_ca_ctrl #(
        .SYNC_STAGES(2),
        .PA_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .ca1_i(ca1_i),
        .ca2_i(ca2_i),
        .ca2_o(ca2_o),
        .ca2_oe(ca2_oe),
        .pa_i(pa_i),
        .pa_lat(pa_lat),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Run n ce ticks; returns on the negedge after the last active edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ce = 1'b1;
            @(negedge clk);
            ce = 1'b0;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        ce            = 1'b0;
        ca1_i         = 1'b1;
        ca2_i         = 1'b1;
        pa_i          = 8'h00;
        bus.pcr       = 4'b0000;
        bus.acr_pa_le = 1'b1;
        bus.ora_rd    = 1'b0;
        bus.ora_wr    = 1'b0;
        bus.ifr_wr    = 1'b0;
        bus.ifr_wdata = 2'b00;
        bus.ier       = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ifr", {30'd0, bus.ifr}, 32'h0);
        checkOutput("rst_ca2_o", {31'd0, ca2_o}, 32'h1);
        checkOutput("rst_pa_lat", {24'd0, pa_lat}, 32'h0);
        rst_n = 1'b1;

        // Idle-high lines produce no edge
        applyStimulus(10);
        checkOutput("idle_ifr", {30'd0, bus.ifr}, 32'h0);
        checkOutput("idle_ca2_o", {31'd0, ca2_o}, 32'h1);
        checkOutput("idle_ca2_oe", {31'd0, ca2_oe}, 32'h0);
        checkOutput("idle_pa_lat", {24'd0, pa_lat}, 32'h0);

        // CA1 negative edge, flag on the third ce edge, PA latched
        pa_i  = 8'hA5;
        ca1_i = 1'b0;
        applyStimulus(2);
        checkOutput("ca1_lat2", {30'd0, bus.ifr}, 32'h0);
        applyStimulus(1);
        checkOutput("ca1_flag", {30'd0, bus.ifr}, 32'h2);
        checkOutput("pa_latched", {24'd0, pa_lat}, 32'hA5);
        pa_i = 8'h3C;
        applyStimulus(2);
        checkOutput("pa_held", {24'd0, pa_lat}, 32'hA5);
        bus.ier = 2'b10;
        #1;
        checkOutput("irq_on", {31'd0, bus.irq_ca}, 32'h1);
        bus.ora_rd = 1'b1;
        applyStimulus(1);
        bus.ora_rd = 1'b0;
        checkOutput("ora_clr_ca1", {30'd0, bus.ifr}, 32'h0);
        checkOutput("irq_off", {31'd0, bus.irq_ca}, 32'h0);
        bus.acr_pa_le = 1'b0;
        applyStimulus(1);
        checkOutput("pa_transp", {24'd0, pa_lat}, 32'h3C);

        // CA2 independent positive edge (mode 011)
        bus.pcr = 4'b0110;
        ca2_i   = 1'b0;
        applyStimulus(3);
        checkOutput("ca2_wrong_edge", {30'd0, bus.ifr}, 32'h0);
        ca2_i = 1'b1;
        applyStimulus(3);
        checkOutput("ca2_pos_flag", {30'd0, bus.ifr}, 32'h1);
        bus.ora_wr = 1'b1;
        applyStimulus(1);
        bus.ora_wr = 1'b0;
        checkOutput("ca2_indep", {30'd0, bus.ifr}, 32'h1);
        bus.ifr_wr    = 1'b1;
        bus.ifr_wdata = 2'b01;
        applyStimulus(1);
        bus.ifr_wr    = 1'b0;
        bus.ifr_wdata = 2'b00;
        checkOutput("ca2_ifr_clr", {30'd0, bus.ifr}, 32'h0);

        // CA2 negative edge (mode 000), ORA clear only on a ce tick
        bus.pcr = 4'b0000;
        ca2_i   = 1'b0;
        applyStimulus(3);
        checkOutput("ca2_neg_flag", {30'd0, bus.ifr}, 32'h1);
        bus.ora_rd = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("ce_gate", {30'd0, bus.ifr}, 32'h1);
        applyStimulus(1);
        bus.ora_rd = 1'b0;
        checkOutput("ca2_ora_clr", {30'd0, bus.ifr}, 32'h0);

        // Handshake output (mode 100, CA1 neg edge)
        bus.pcr = 4'b1000;
        applyStimulus(1);
        checkOutput("hs_load", {31'd0, ca2_o}, 32'h1);
        checkOutput("hs_oe", {31'd0, ca2_oe}, 32'h1);
        bus.ora_rd = 1'b1;
        applyStimulus(1);
        bus.ora_rd = 1'b0;
        checkOutput("hs_low", {31'd0, ca2_o}, 32'h0);
        ca1_i = 1'b1;
        applyStimulus(3);
        checkOutput("hs_pos_ignored", {31'd0, ca2_o}, 32'h0);
        ca1_i = 1'b0;
        applyStimulus(2);
        checkOutput("hs_still_low", {31'd0, ca2_o}, 32'h0);
        applyStimulus(1);
        checkOutput("hs_release", {31'd0, ca2_o}, 32'h1);
        checkOutput("hs_ca1_flag", {30'd0, bus.ifr}, 32'h2);
        ca1_i = 1'b1;
        applyStimulus(3);
        bus.ora_rd = 1'b1;
        applyStimulus(1);
        bus.ora_rd = 1'b0;
        checkOutput("hs_low2", {31'd0, ca2_o}, 32'h0);
        checkOutput("hs_ifr_clr", {30'd0, bus.ifr}, 32'h0);
        ca1_i = 1'b0;
        applyStimulus(2);
        bus.ora_rd = 1'b1;
        applyStimulus(1);
        bus.ora_rd = 1'b0;
        checkOutput("hs_edge_wins", {31'd0, ca2_o}, 32'h1);
        checkOutput("hs_set_wins", {30'd0, bus.ifr}, 32'h2);

        // Pulse output (mode 101)
        bus.pcr = 4'b1010;
        applyStimulus(1);
        checkOutput("pulse_idle", {31'd0, ca2_o}, 32'h1);
        bus.ora_wr = 1'b1;
        applyStimulus(1);
        bus.ora_wr = 1'b0;
        checkOutput("pulse_low", {31'd0, ca2_o}, 32'h0);
        applyStimulus(1);
        checkOutput("pulse_end", {31'd0, ca2_o}, 32'h1);
        bus.ora_wr = 1'b1;
        applyStimulus(1);
        checkOutput("pulse2_low1", {31'd0, ca2_o}, 32'h0);
        applyStimulus(1);
        bus.ora_wr = 1'b0;
        checkOutput("pulse2_low2", {31'd0, ca2_o}, 32'h0);
        applyStimulus(1);
        checkOutput("pulse2_end", {31'd0, ca2_o}, 32'h1);

        // Manual outputs and reload on entering handshake
        bus.pcr = 4'b1100;
        applyStimulus(1);
        checkOutput("manual_low", {31'd0, ca2_o}, 32'h0);
        bus.pcr = 4'b1110;
        applyStimulus(1);
        checkOutput("manual_high", {31'd0, ca2_o}, 32'h1);
        bus.pcr = 4'b1100;
        applyStimulus(1);
        bus.pcr = 4'b1000;
        applyStimulus(1);
        checkOutput("hs_reload", {31'd0, ca2_o}, 32'h1);

        // Set/clear collision on the CA1 flag
        bus.pcr = 4'b1010;
        ca1_i   = 1'b1;
        applyStimulus(3);
        checkOutput("pre_collide", {30'd0, bus.ifr}, 32'h0);
        ca1_i = 1'b0;
        applyStimulus(2);
        bus.ifr_wr    = 1'b1;
        bus.ifr_wdata = 2'b10;
        applyStimulus(1);
        checkOutput("collide_set", {30'd0, bus.ifr}, 32'h2);
        applyStimulus(1);
        bus.ifr_wr    = 1'b0;
        bus.ifr_wdata = 2'b00;
        checkOutput("ifr_wr_clr", {30'd0, bus.ifr}, 32'h0);

        // Async reset in the middle of a CA2 pulse
        ca1_i = 1'b1;
        applyStimulus(3);
        ca1_i = 1'b0;
        applyStimulus(2);
        bus.ora_wr = 1'b1;
        applyStimulus(1);
        bus.ora_wr = 1'b0;
        checkOutput("mid_pulse", {31'd0, ca2_o}, 32'h0);
        checkOutput("mid_ifr", {30'd0, bus.ifr}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ca2_o", {31'd0, ca2_o}, 32'h1);
        checkOutput("arst_ifr", {30'd0, bus.ifr}, 32'h0);
        checkOutput("arst_pa_lat", {24'd0, pa_lat}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
